pulse_to_level: RTL
===================

PULSE_TO_LEVEL -- requirements
Module: pulse_to_level

Interface
REQ-001 SHALL provide parameter HOLD_CYCLES, default 8, meaning level high time per accepted pulse in clk cycles (legal >= 1).
REQ-002 SHALL provide parameter COOLDOWN_CYCLES, default 4, meaning forced low time after each hold (legal >= 0).
REQ-003 SHALL provide parameter CNT_W, default 16, meaning width of the hold/cooldown counter (must hold max(HOLD_CYCLES, COOLDOWN_CYCLES) - 1).
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL provide port pulse, input, 1 bit: single-cycle event from the level-to-pulse edge detectors (level change or irrigation request).
REQ-007 SHALL provide port stop, input, 1 bit: abort request.
REQ-008 SHALL provide port retrig_en, input, 1 bit: when high, a pulse during hold restarts the hold.
REQ-009 SHALL provide port level, output, 1 bit: held actuator drive (valve/pump), registered.
REQ-010 SHALL provide port cooldown, output, 1 bit: high while in COOLDOWN state.
REQ-011 SHALL provide port remaining, output, CNT_W bits: cycles left in current HOLD or COOLDOWN minus one; 0 in IDLE.
REQ-012 SHALL provide port dropped, output, 1 bit: one-cycle strobe when a pulse is not accepted.
REQ-013 SHALL provide port dropped_cnt, output, 8 bits: saturating count of dropped pulses.

Function
REQ-014 SHALL implement states IDLE, HOLD, COOLDOWN; level = 1 exactly in HOLD, cooldown = 1 exactly in COOLDOWN.
REQ-015 IDLE with pulse=1 at edge k SHALL enter HOLD at edge k with remaining = HOLD_CYCLES-1 (level high the cycle after pulse, latency 1).
REQ-016 In HOLD, remaining SHALL decrement by 1 each cycle; at remaining=0 with no accepted pulse, next state SHALL be COOLDOWN with remaining = COOLDOWN_CYCLES-1, or IDLE if COOLDOWN_CYCLES=0.
REQ-017 Level SHALL therefore stay high exactly HOLD_CYCLES cycles per untriggered, unstopped hold.
REQ-018 In HOLD, pulse=1 with retrig_en=1 and stop=0 SHALL reload remaining to HOLD_CYCLES-1, including at remaining=0; no glitch on level.
REQ-019 In HOLD, pulse=1 with retrig_en=0 SHALL be dropped; hold timing unchanged.
REQ-020 In COOLDOWN, remaining SHALL decrement each cycle; at remaining=0, next state IDLE; any pulse in COOLDOWN SHALL be dropped, including at remaining=0.
REQ-021 stop=1 in HOLD SHALL force COOLDOWN (or IDLE if COOLDOWN_CYCLES=0) at that edge, with remaining = COOLDOWN_CYCLES-1.
REQ-022 stop=1 in IDLE or COOLDOWN SHALL have no effect.
REQ-023 stop=1 and pulse=1 in the same cycle SHALL: in IDLE accept the pulse; in HOLD apply stop and drop the pulse; in COOLDOWN drop the pulse.
REQ-024 Each dropped pulse SHALL assert dropped for exactly one cycle (the cycle after the pulse) and increment dropped_cnt, saturating at 255.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, level=0, cooldown=0, remaining=0, dropped=0, dropped_cnt=0, regardless of state or concurrent pulse/stop.
REQ-026 Reset asserted mid-HOLD SHALL drop level the cycle after the reset edge with no COOLDOWN phase; a pulse in the first cycle after rst deasserts SHALL be accepted.

Structure
REQ-027 State enumeration (IDLE, HOLD, COOLDOWN) and default HOLD_CYCLES/COOLDOWN_CYCLES constants SHALL live in the shared irrigation package.
REQ-028 The loadable down-counter SHALL be one sub-module, down_counter (load, load_value, enable, zero flag); all other logic stays in pulse_to_level.

Verification (HOLD_CYCLES=4, COOLDOWN_CYCLES=3)
REQ-029 Single pulse at cycle 0 -> level high cycles 1-4, cooldown high 5-7, IDLE at 8, dropped never.
REQ-030 retrig_en=1, pulses at cycles 0 and 3 -> level high cycles 1-7 continuous, cooldown 8-10.
REQ-031 retrig_en=0, pulses at 0, 2, 6 -> level 1-4 only; dropped strobes at cycles 3 and 7; dropped_cnt=2.
REQ-032 Pulse at 0, stop+pulse at 2 -> level 1-2, cooldown 3-5, dropped at 3, dropped_cnt=1.
REQ-033 Pulse at 0, rst at 2 -> all outputs zero from cycle 3; pulse at 3 -> level high cycles 4-7.
REQ-034 300 pulses during permanent retrig_en=0 hold/cooldown cycling -> dropped_cnt saturates at 255, no wrap.

Source files
------------

// File: rtl/pulse_to_level_pkg.sv
// Shared irrigation package for the pulse-to-level actuator driver.
// Holds the FSM state enumeration and the default hold and cooldown
// durations used by pulse_to_level.
package pulse_to_level_pkg;

  // Default level high time per accepted pulse, in clk cycles (>= 1).
  localparam int unsigned DEF_HOLD_CYCLES     = 8;
  // Default forced low time after each hold, in clk cycles (>= 0).
  localparam int unsigned DEF_COOLDOWN_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_to_level_down_counter.sv
// Loadable down-counter used to time the HOLD and COOLDOWN phases.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset, clears count
//   load       - load load_value (takes priority over enable)
//   load_value - value to load
//   enable     - decrement count by one
//   count      - current counter value
//   zero       - high when count is zero
module down_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_to_level.sv
// Converts single-cycle event pulses into a held actuator drive level.
// Each accepted pulse holds level high for HOLD_CYCLES cycles, followed by
// a forced-low cooldown of COOLDOWN_CYCLES cycles. Pulses that cannot be
// accepted are reported on dropped and counted (saturating) in dropped_cnt.
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   pulse       - single-cycle trigger event
//   stop        - abort the current hold
//   retrig_en   - allow a pulse during hold to restart the hold
//   level       - registered actuator drive, high exactly in HOLD
//   cooldown    - high exactly in COOLDOWN
//   remaining   - cycles left in current HOLD/COOLDOWN minus one, 0 in IDLE
//   dropped     - one-cycle strobe after a rejected pulse
//   dropped_cnt - saturating count of rejected pulses
module pulse_to_level
  import pulse_to_level_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse,
  input  logic             stop,
  input  logic             retrig_en,
  output logic             level,
  output logic             cooldown,
  output logic [CNT_W-1:0] remaining,
  output logic             dropped,
  output logic [7:0]       dropped_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  // With no cooldown phase the counter is loaded with zero so that IDLE
  // always reads remaining = 0 without a separate clear path.
  localparam logic [CNT_W-1:0] COOL_LOAD =
    (COOLDOWN_CYCLES == 0) ? '0 : CNT_W'(COOLDOWN_CYCLES - 1);
  localparam state_t AFTER_HOLD = (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;

  state_t           state, state_n;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_value;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             drop;

  down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .enable     (cnt_dec),
    .count      (remaining),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_n        = state;
    cnt_load       = 1'b0;
    cnt_load_value = HOLD_LOAD;
    cnt_dec        = 1'b0;
    drop           = 1'b0;
    case (state)
      IDLE: begin
        if (pulse) begin
          state_n  = HOLD;
          cnt_load = 1'b1;
        end
      end
      HOLD: begin
        if (stop) begin
          drop           = pulse;
          state_n        = AFTER_HOLD;
          cnt_load       = 1'b1;
          cnt_load_value = COOL_LOAD;
        end else if (pulse && retrig_en) begin
          // Reload in place; state stays HOLD so level never glitches.
          cnt_load = 1'b1;
        end else begin
          drop = pulse;
          if (cnt_zero) begin
            state_n        = AFTER_HOLD;
            cnt_load       = 1'b1;
            cnt_load_value = COOL_LOAD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      COOLDOWN: begin
        drop = pulse;
        if (cnt_zero) begin
          state_n = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      level       <= 1'b0;
      cooldown    <= 1'b0;
      dropped     <= 1'b0;
      dropped_cnt <= '0;
    end else begin
      state    <= state_n;
      level    <= (state_n == HOLD);
      cooldown <= (state_n == COOLDOWN);
      dropped  <= drop;
      if (drop && (dropped_cnt != '1)) begin
        dropped_cnt <= dropped_cnt + 8'd1;
      end
    end
  end

endmodule
